// File: rtl/axi_apb_txn_scheduler.sv
// AXI4-Lite front-end for the APB bridge: round-robin AW+W / AR arbitration,
// slave decode, single APB request with timeout watchdog, B/R response return.
module axi_apb_txn_scheduler #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 3,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 255
) (
    input  logic                  s_axi_clk,
    input  logic                  s_axi_aresetn,
    input  logic [31:0]           s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [31:0]           s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_write,
    output logic [31:0]           req_addr,
    output logic [31:0]           req_wdata,
    output logic [3:0]            req_strb,
    output logic [NUM_SLAVES-1:0] req_sel,
    input  logic                  req_done,
    input  logic                  req_err,
    input  logic [31:0]           req_rdata,
    output logic                  req_abort
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_ISSUE, S_WAIT, S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  dir_q, dir_d;
    logic                  last_wr_q, last_wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  awready_q, awready_d;
    logic                  arready_q, arready_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rqv_q, rqv_d;
    logic                  rqw_q, rqw_d;
    logic [31:0]           rqa_q, rqa_d;
    logic [31:0]           rqd_q, rqd_d;
    logic [3:0]            rqs_q, rqs_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic                  abort_q, abort_d;

    logic             wr_el, rd_el, gnt_wr;
    logic [31:0]      acc_addr;
    logic [SEL_W-1:0] idx;
    logic             dec_ok, expired, resp_hs;

    assign wr_el    = s_axi_awvalid & s_axi_wvalid;
    assign rd_el    = s_axi_arvalid;
    // Contention goes to the direction that did not win last time
    assign gnt_wr   = wr_el & (~rd_el | ~last_wr_q);
    assign acc_addr = dir_q ? s_axi_awaddr : s_axi_araddr;
    assign idx      = acc_addr[SEL_LSB +: SEL_W];
    assign dec_ok   = 32'(idx) < NUM_SLAVES;
    assign expired  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign resp_hs  = dir_q ? s_axi_bready : s_axi_rready;

    always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            last_wr_q <= 1'b1;
            cnt_q     <= '0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bresp_q   <= '0;
            bvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rqv_q     <= 1'b0;
            rqw_q     <= 1'b0;
            rqa_q     <= '0;
            rqd_q     <= '0;
            rqs_q     <= '0;
            sel_q     <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            bresp_q   <= bresp_d;
            bvalid_q  <= bvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rqv_q     <= rqv_d;
            rqw_q     <= rqw_d;
            rqa_q     <= rqa_d;
            rqd_q     <= rqd_d;
            rqs_q     <= rqs_d;
            sel_q     <= sel_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        last_wr_d = last_wr_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_el | rd_el) begin
                    dir_d     = gnt_wr;
                    last_wr_d = gnt_wr;
                    state_d   = S_ACCEPT;
                end
            end
            S_ACCEPT: state_d = dec_ok ? S_ISSUE : S_RESP;
            S_ISSUE: begin
                if (req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (req_done || expired) state_d = S_RESP;
            end
            S_RESP: if (resp_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        awready_d = 1'b0;
        arready_d = 1'b0;
        rqv_d     = 1'b0;
        abort_d   = 1'b0;
        rqw_d     = rqw_q;
        rqa_d     = rqa_q;
        rqd_d     = rqd_q;
        rqs_d     = rqs_q;
        sel_d     = sel_q;
        bresp_d   = bresp_q;
        bvalid_d  = bvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_el | rd_el) begin
                    awready_d = gnt_wr;
                    arready_d = ~gnt_wr;
                end
            end
            S_ACCEPT: begin
                rqw_d = dir_q;
                rqa_d = acc_addr;
                rqd_d = dir_q ? s_axi_wdata : 32'h0;
                rqs_d = dir_q ? s_axi_wstrb : 4'h0;
                if (dec_ok) begin
                    sel_d = NUM_SLAVES'(1) << idx;
                    rqv_d = 1'b1;
                end else begin
                    sel_d    = '0;
                    bresp_d  = dir_q ? 2'b11 : 2'b00;
                    rresp_d  = dir_q ? 2'b00 : 2'b11;
                    rdata_d  = '0;
                    bvalid_d = dir_q;
                    rvalid_d = ~dir_q;
                end
            end
            S_ISSUE: rqv_d = ~req_ready;
            S_WAIT: begin
                if (req_done) begin
                    bresp_d  = dir_q ? {req_err, 1'b0} : 2'b00;
                    rresp_d  = dir_q ? 2'b00 : {req_err, 1'b0};
                    rdata_d  = dir_q ? 32'h0 : req_rdata;
                    bvalid_d = dir_q;
                    rvalid_d = ~dir_q;
                end else if (expired) begin
                    abort_d  = 1'b1;
                    bresp_d  = dir_q ? 2'b10 : 2'b00;
                    rresp_d  = dir_q ? 2'b00 : 2'b10;
                    rdata_d  = '0;
                    bvalid_d = dir_q;
                    rvalid_d = ~dir_q;
                end
            end
            S_RESP: begin
                if (resp_hs) begin
                    bresp_d  = '0;
                    bvalid_d = 1'b0;
                    rresp_d  = '0;
                    rdata_d  = '0;
                    rvalid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rvalid  = rvalid_q;
    assign req_valid     = rqv_q;
    assign req_write     = rqw_q;
    assign req_addr      = rqa_q;
    assign req_wdata     = rqd_q;
    assign req_strb      = rqs_q;
    assign req_sel       = sel_q;
    assign req_abort     = abort_q;

endmodule

// File: tb/tb_axi_apb_txn_scheduler.sv
// Bench for axi_apb_txn_scheduler: vector table + scoreboard queues,
// APB responder and AXI response monitor running alongside the stimulus.
`timescale 1ns/1ps
module tb_axi_apb_txn_scheduler;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b0, rready = 1'b0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        req_valid, req_write, req_abort;
    logic        req_ready = 1'b0, req_done = 1'b0, req_err = 1'b0;
    logic [31:0] req_addr, req_wdata, req_rdata = '0;
    logic [3:0]  req_strb, req_sel;

    always #5 clk = ~clk;

    axi_apb_txn_scheduler #(
        .NUM_SLAVES(4), .SEL_W(3), .SEL_LSB(12), .TIMEOUT(TO)
    ) dut (
        .s_axi_clk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
        .s_axi_rready(rready),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_sel(req_sel), .req_done(req_done), .req_err(req_err),
        .req_rdata(req_rdata), .req_abort(req_abort)
    );

    typedef struct {
        logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;
        logic err; logic [31:0] rd_in; int dly; int hold;
        logic [3:0] e_sel; logic [1:0] e_resp; logic [31:0] e_rdata;
        logic e_abort; int e_lat;
    } vec_t;

    typedef struct {
        logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [3:0] sel;
        logic err; logic [31:0] rd_in; int dly;
    } req_t;

    typedef struct {
        logic [1:0] resp; logic [31:0] rdata; logic abort;
        int lat; int t0; int hold;
    } rsp_t;

    req_t rqw[$], rqr[$];
    rsp_t sqw[$], sqr[$];
    bit   order[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int n_req = 0, abort_cnt = 0, abort_base = 0;
    bit busy = 0, post = 0, have = 0, cur_wr = 0, prev_ab = 0, last_acc = 0;
    int hc = 0;
    rsp_t cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] d,
                                logic [3:0] s, bit e, logic [31:0] ri,
                                int dl, int h, logic [3:0] es,
                                logic [1:0] er, logic [31:0] ed,
                                bit ea, int el);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.err = e;
        v.rd_in = ri; v.dly = dl; v.hold = h; v.e_sel = es;
        v.e_resp = er; v.e_rdata = ed; v.e_abort = ea; v.e_lat = el;
        return v;
    endfunction

    task automatic drive(input vec_t v, input bit push_rsp);
        req_t rq;
        rsp_t rs;
        int n;
        @(negedge clk);
        rq.addr = v.addr;
        rq.wdata = v.wr ? v.wdata : 32'h0;
        rq.strb = v.wr ? v.strb : 4'h0;
        rq.sel = v.e_sel; rq.err = v.err; rq.rd_in = v.rd_in; rq.dly = v.dly;
        if (v.e_sel != 4'h0) begin
            if (v.wr) rqw.push_back(rq);
            else rqr.push_back(rq);
        end
        rs.resp = v.e_resp; rs.rdata = v.e_rdata; rs.abort = v.e_abort;
        rs.lat = v.e_lat; rs.t0 = cyc; rs.hold = v.hold;
        if (push_rsp) begin
            if (v.wr) sqw.push_back(rs);
            else sqr.push_back(rs);
        end
        if (v.wr) begin
            awaddr = v.addr; wdata = v.wdata; wstrb = v.strb;
            awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = v.addr; arvalid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(v.wr ? awready : arready) && n < 100);
        if (n >= 100) fail("accept_wait");
        @(negedge clk);
        if (v.wr) begin awvalid = 1'b0; wvalid = 1'b0; end
        else arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rqw.size() + rqr.size() + sqw.size() + sqr.size()) != 0 || busy) begin
            @(negedge clk);
            n++;
            if (n >= 400) begin
                fail("drain_wait");
                rqw.delete(); rqr.delete(); sqw.delete(); sqr.delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // APB side: accepts each request at once, completes after its scripted delay
    initial begin
        req_t rq;
        bit ok;
        forever begin
            @(negedge clk);
            req_ready = 1'b0; req_done = 1'b0; req_err = 1'b0; req_rdata = '0;
            if (rst_n && req_valid) begin
                n_req++;
                ok = 1'b1;
                if (req_write) begin
                    if (rqw.size() == 0) ok = 1'b0; else rq = rqw.pop_front();
                end else begin
                    if (rqr.size() == 0) ok = 1'b0; else rq = rqr.pop_front();
                end
                req_ready = 1'b1;
                if (!ok) fail("unexpected_req");
                else begin
                    chk("req_write", req_write, last_acc);
                    chk("req_sel", req_sel, rq.sel);
                    chk("req_addr", req_addr, rq.addr);
                    chk("req_wdata", req_wdata, rq.wdata);
                    chk("req_strb", req_strb, rq.strb);
                    @(negedge clk);
                    req_ready = 1'b0;
                    if (rq.dly >= 0) begin
                        repeat (rq.dly) @(negedge clk);
                        chk("req_sel_stable", req_sel, rq.sel);
                        req_done = 1'b1; req_err = rq.err; req_rdata = rq.rd_in;
                        @(negedge clk);
                        req_done = 1'b0; req_err = 1'b0; req_rdata = '0;
                    end
                end
            end
        end
    end

    // AXI response side: pops the scoreboard and drives bready/rready
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0; post = 0; prev_ab = 0; bready = 0; rready = 0;
                continue;
            end
            if (awready | wready | arready) begin
                chk("aw_w_ready_pair", awready, wready);
                chk("single_ready", (awready | wready) & arready, 1'b0);
                if (arready) begin order.push_back(1'b0); last_acc = 1'b0; end
                else begin order.push_back(1'b1); last_acc = 1'b1; end
            end
            if (req_abort) begin
                abort_cnt++;
                chk("abort_1cyc", prev_ab, 1'b0);
            end
            prev_ab = req_abort;
            if (post) begin
                post = 0;
                chk("valid_drop", {bvalid, rvalid}, 2'b00);
                chk("payload_clear", {bresp, rresp, rdata}, 36'h0);
            end
            if (bvalid | rvalid) begin
                if (!busy) begin
                    chk("one_valid", bvalid & rvalid, 1'b0);
                    cur_wr = bvalid;
                    have = 1'b1;
                    if (cur_wr && sqw.size() != 0) cur = sqw.pop_front();
                    else if (!cur_wr && sqr.size() != 0) cur = sqr.pop_front();
                    else have = 1'b0;
                    busy = 1; hc = 0;
                    if (!have) fail("unexpected_resp");
                    else begin
                        if (cur.lat != 0) chk("latency", cyc - cur.t0, cur.lat);
                        chk("abort_count", abort_cnt - abort_base, cur.abort);
                    end
                    abort_base = abort_cnt;
                end
                if (have) begin
                    if (cur_wr) chk("bresp", bresp, cur.resp);
                    else begin
                        chk("rresp", rresp, cur.resp);
                        chk("rdata", rdata, cur.rdata);
                    end
                end
                if (!have || hc >= cur.hold) begin
                    bready = cur_wr; rready = ~cur_wr;
                    busy = 0; post = 1;
                end else begin
                    bready = 0; rready = 0;
                end
                hc++;
            end else begin
                bready = 0; rready = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[10];
        vec_t v;
        int n0, n;
        bit [3:0] ob;

        tbl[0] = mk(1, 32'h0000_2010, 32'hA5A5_5A5A, 4'hF, 0, 32'h1234_5678,
                    0, 3, 4'b0100, 2'b00, 32'h0, 0, 4);
        tbl[1] = mk(0, 32'h0000_1004, 32'h0, 4'h0, 1, 32'hDEAD_BEEF,
                    0, 1, 4'b0010, 2'b10, 32'hDEAD_BEEF, 0, 4);
        tbl[2] = mk(1, 32'h0000_0000, 32'h1234_5678, 4'h3, 1, 32'h0,
                    0, 0, 4'b0001, 2'b10, 32'h0, 0, 4);
        tbl[3] = mk(0, 32'h0000_3FFC, 32'h0, 4'h0, 0, 32'hCAFE_F00D,
                    3, 2, 4'b1000, 2'b00, 32'hCAFE_F00D, 0, 7);
        tbl[4] = mk(0, 32'h0000_5000, 32'h0, 4'h0, 0, 32'h0,
                    0, 1, 4'b0000, 2'b11, 32'h0, 0, 2);
        tbl[5] = mk(1, 32'h0000_7000, 32'hAAAA_5555, 4'hF, 0, 32'h0,
                    0, 0, 4'b0000, 2'b11, 32'h0, 0, 2);
        tbl[6] = mk(1, 32'h0000_4000, 32'h0101_0101, 4'h1, 0, 32'h0,
                    0, 0, 4'b0000, 2'b11, 32'h0, 0, 2);
        tbl[7] = mk(0, 32'hFFFF_3000, 32'h0, 4'h0, 0, 32'h0BAD_F00D,
                    7, 0, 4'b1000, 2'b00, 32'h0BAD_F00D, 0, 11);
        tbl[8] = mk(1, 32'h0000_1000, 32'h5A5A_0000, 4'hC, 0, 32'h0,
                    -1, 1, 4'b0010, 2'b10, 32'h0, 1, 11);
        tbl[9] = mk(0, 32'h0000_2000, 32'h0, 4'h0, 0, 32'h1111_1111,
                    -1, 0, 4'b0100, 2'b10, 32'h0, 1, 11);

        repeat (3) @(negedge clk);
        chk("rst_ready", {awready, wready, arready}, 3'b0);
        chk("rst_bchan", {bvalid, bresp}, 3'b0);
        chk("rst_rchan", {rvalid, rresp, rdata}, 35'h0);
        chk("rst_req_ctl", {req_valid, req_write, req_sel, req_abort}, 7'h0);
        chk("rst_req_data", {req_addr, req_wdata, req_strb}, 68'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Both directions continuously requesting: read first after reset
        order.delete();
        fork
            begin
                drive(mk(1, 32'h0000_1100, 32'h1111_0000, 4'hF, 0, 32'h0,
                         0, 0, 4'b0010, 2'b00, 32'h0, 0, 0), 1);
                drive(mk(1, 32'h0000_3300, 32'h3333_0000, 4'h5, 0, 32'h0,
                         0, 0, 4'b1000, 2'b00, 32'h0, 0, 0), 1);
            end
            begin
                drive(mk(0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0101_0101,
                         0, 0, 4'b0001, 2'b00, 32'h0101_0101, 0, 0), 1);
                drive(mk(0, 32'h0000_2200, 32'h0, 4'h0, 1, 32'h0202_0202,
                         0, 0, 4'b0100, 2'b10, 32'h0202_0202, 0, 0), 1);
            end
        join
        wait_idle();
        chk("grant_count", order.size(), 4);
        if (order.size() >= 4) begin
            ob = {order[0], order[1], order[2], order[3]};
            chk("grant_order", ob, 4'b0101);
        end

        // Half a write is never eligible
        @(negedge clk);
        awaddr = 32'h0000_0000; awvalid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("aw_only_idle", {awready, wready, arready, req_valid}, 4'h0);
        end
        awvalid = 1'b0; wvalid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("w_only_idle", {awready, wready, arready, req_valid}, 4'h0);
        end
        wvalid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i], 1);
            wait_idle();
        end

        // Reset while the request is waiting for completion
        v = mk(1, 32'h0000_3008, 32'hFEED_FACE, 4'hF, 0, 32'h0,
               -1, 0, 4'b1000, 2'b00, 32'h0, 0, 0);
        n0 = n_req;
        drive(v, 0);
        n = 0;
        while (n_req == n0 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail("reset_req_wait");
        repeat (3) @(negedge clk);
        chk("pre_reset_sel", req_sel, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", {awready, wready, arready}, 3'b0);
        chk("async_rst_resp", {bvalid, bresp, rvalid, rresp, rdata}, 38'h0);
        chk("async_rst_req_ctl", {req_valid, req_write, req_sel, req_abort}, 7'h0);
        chk("async_rst_req_data", {req_addr, req_wdata, req_strb}, 68'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_resp_after_rst", {bvalid, rvalid}, 2'b00);

        drive(mk(0, 32'h0000_2000, 32'h0, 4'h0, 0, 32'h600D_CAFE,
                 0, 1, 4'b0100, 2'b00, 32'h600D_CAFE, 0, 4), 1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
